// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: per-channel 2-FF synchroniser, shared tick prescaler,
// DEPTH-sample debounce history and IDLE/PRESSED/LONG FSM with press/release/long pulses.
module btn_debounce_multi #(
  parameter int NUM_BTN    = 2,
  parameter int TICK_DIV   = 100000,
  parameter int DEPTH      = 8,
  parameter int LONG_TICKS = 500,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_held,
  output logic               tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam bit                 LONG_EN   = (LONG_TICKS != 0);
  localparam logic [CNT_W-1:0]   LONG_LAST = LONG_EN ? CNT_W'(LONG_TICKS - 1) : '0;
  localparam logic [NUM_BTN-1:0] POL       = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  // Hold counter saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DIV_W-1:0]   div_q, div_d;
  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  logic               tick_w;

  assign tick_w = (div_q == DIV_LAST);
  assign tick   = tick_w;

  always_comb begin
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    sync1_d = btn_in ^ POL;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      div_q   <= div_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [DEPTH-1:0] hist_q, hist_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

    // Decisions look at the freshly shifted history within the tick cycle.
    always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      if (tick_w) begin
        hist_d = {hist_q[DEPTH-2:0], sync2_q[i]};
        case (state_q)
          IDLE: begin
            if (&hist_d) begin
              state_d = PRESSED;
              press_d = 1'b1;
              cnt_d   = '0;
            end
          end
          PRESSED: begin
            if (~|hist_d) begin
              state_d   = IDLE;
              release_d = 1'b1;
            end else if (LONG_EN && (cnt_q == LONG_LAST)) begin
              state_d = LONG;
              long_d  = 1'b1;
            end else begin
              cnt_d = sat_inc(cnt_q);
            end
          end
          LONG: begin
            if (~|hist_d) begin
              state_d   = IDLE;
              release_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= IDLE;
        hist_q    <= '0;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        hist_q    <= hist_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    assign btn_state[i]   = (state_q != IDLE);
    assign btn_held[i]    = (state_q == LONG);
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
  end

endmodule
